sprite_layer: RTL
=================

# sprite_layer

Parametrised, double-buffered sprite renderer for the VGA pipeline: it decodes 32-bit sprite commands from the Avalon bus, holds per-child sprite state in two banks, and produces one 24-bit pixel per clock for the current hcount/vcount. It generalises the fixed two-child tube renderer to N children, N patterns and configurable pixel depth. It adds four things: a write strobe, a deferred buffer swap, a registered three-stage pixel pipeline and a transparent colour index. One instance per sprite type sits in front of the final colour mux.

## Interface
- COMPONENT_ID, 6'b001010, command component ID this instance answers to
- N_CHILDREN, 4, sprite instances per buffer (1..32)
- N_PATTERNS, 4, pattern table entries (1..32)
- PIX_BITS, 2, bits per stored pixel (palette index width)
- MEM_DEPTH, 576, sprite memory depth in pixels
- MEM_INIT_FILE, "", $readmemh image for sprite memory
- PATTERN_TABLE, 0, N_PATTERNS x {base[15:0], width[9:0], height[9:0]}, entry 0 in LSBs
- PALETTE, 0, (2**PIX_BITS) x 24-bit RGB, entry 0 in LSBs
- BG_COLOR, 24'h202020, colour when no child hits or pixel is transparent
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- write  in  1  writedata valid this cycle
- writedata  in  32  command word
- hcount  in  10  current pixel column
- vcount  in  10  current pixel row
- RGB_output  out  24  pixel colour, registered
- active_buffer  out  1  bank currently displayed
- swap_pending  out  1  swap requested and not yet applied

## Operation
- Command fields:
  - [31:26] component id
  - [25:21] child
  - [20:17] control
  - [16:14] type
  - [13] bank
  - [12:0] data
- Commands are accepted only when write=1.
- Control 4'hF (swap): accepted regardless of component id. It latches the pending bank from [13] and sets swap_pending. A second swap while pending overwrites the target.
- Control 4'h1 (set child): requires id == COMPONENT_ID and child < N_CHILDREN, otherwise ignored. It writes bank [13] of that child, selected by type:
  - 001: pattern index = data[4:0], ignored if >= N_PATTERNS
  - 010: x = data[9:0]
  - 011: y = data[9:0]
  - 100: visible = data[12], flip = data[11]
- Other control or type codes are ignored.
- Swap apply: active_buffer becomes the pending bank and swap_pending clears. The visible bit of every child in the new back bank clears, except a child written in the same cycle by a type-100 command, whose written value wins.
- Hit for child i:
  - visible, x <= hcount < x+width, y <= vcount < y+height
  - All sums are computed in 11 bits, so there is no wrap at 1023.
- Address = base + (vcount-y)*width + (flip ? width-1-(hcount-x) : hcount-x), computed 20-bit unsigned.
- Priority: the lowest-index hitting child in the active bank wins.
- Pixel selection:
  - If the address is >= MEM_DEPTH, pixel index 0 is used.
  - Index 0 outputs BG_COLOR (transparent).
  - Any other index outputs PALETTE[index].
- Writes to the displayed bank take effect immediately. Tearing is permitted.

## Timing
- Stage 1 registers winner hit and address from hcount/vcount at cycle t.
- Stage 2 performs a synchronous memory read.
- Stage 3 registers RGB_output.
- Latency is 3 cycles: hcount/vcount at t gives RGB_output at t+3. Throughput is one pixel per clock.
- Command state updates on the edge after write. It affects stage 1 from the next cycle.
- Reset (asynchronous assert, synchronous deassert use) produces:
  - all child state zero (invisible) in both banks
  - active_buffer=0, swap_pending=0
  - pipeline hit bits cleared
  - RGB_output=BG_COLOR
- Reset mid-frame discards in-flight pixels. Output is BG_COLOR until 3 cycles after reset release.

## Configuration
- SPRITE_LAYER_VSYNC_SWAP_EN defined: a swap applies on the first cycle with hcount==0 && vcount==0 after acceptance. If the command arrives in that same cycle, it applies at the next frame start.
- Undefined: a swap applies on the clock edge that accepts the command. swap_pending then only ever reads 0.

## Structure
- Package sprite_pkg holds:
  - field-position constants
  - control codes (CTRL_SWAP=4'hF, CTRL_SET=4'h1) and type codes
  - typedefs child_state_t {pattern, x, y, visible, flip} and pattern_t {base, width, height}
- Sub-module sprite_addr_gen: combinational hit/address for one child, instantiated N_CHILDREN times on the active bank.

## Test plan
- **Set and display:** child 0 pattern 0 {base 0, w 32, h 16}, x=100, y=50, visible. Stimulus: hcount=100, vcount=50. Required: RGB_output at t+3 = PALETTE[mem[0]]. hcount=132 gives BG_COLOR.
- **Flip:** same child with flip=1 at hcount=100. Required: address 31 is used.
- **Priority and transparency:**
  - Children 0 and 1 overlap: child 0 colour is output.
  - With mem index 0 at that address: BG_COLOR is output, not child 1.
- **Deferred swap (macro on):**
  - Swap to bank 1 at hcount=5, vcount=0: swap_pending=1, active_buffer stays 0 until hcount=0, vcount=0, then becomes 1.
  - Bank-0 visible bits are cleared.
- **Ignored commands:** wrong component id, child=N_CHILDREN, pattern=N_PATTERNS, write=0. Required: no state change.
- **Reset mid-frame:** reset=0 during an active sprite. Required: RGB_output=BG_COLOR immediately, and all children invisible after release.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared command field layout, opcode values and sprite state types
// for the sprite_layer renderer.
package sprite_pkg;

  localparam int ID_LSB      = 26;
  localparam int ID_W        = 6;
  localparam int CHILD_LSB   = 21;
  localparam int CHILD_W     = 5;
  localparam int CTRL_LSB    = 17;
  localparam int CTRL_W      = 4;
  localparam int TYPE_LSB    = 14;
  localparam int TYPE_W      = 3;
  localparam int BANK_BIT    = 13;
  localparam int DATA_W      = 13;
  localparam int PAT_ENTRY_W = 36;

  localparam logic [3:0] CTRL_SWAP = 4'hF;
  localparam logic [3:0] CTRL_SET  = 4'h1;

  localparam logic [2:0] TYPE_PATTERN = 3'b001;
  localparam logic [2:0] TYPE_X       = 3'b010;
  localparam logic [2:0] TYPE_Y       = 3'b011;
  localparam logic [2:0] TYPE_FLAGS   = 3'b100;

  typedef struct packed {
    logic [4:0] pattern;
    logic [9:0] x;
    logic [9:0] y;
    logic       visible;
    logic       flip;
  } child_state_t;

  // Field order matches the packed pattern-table entry {base, width, height}.
  typedef struct packed {
    logic [15:0] base;
    logic [9:0]  width;
    logic [9:0]  height;
  } pattern_t;

  function automatic pattern_t unpack_pattern(input logic [PAT_ENTRY_W-1:0] entry);
    return pattern_t'(entry);
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Combinational hit test and sprite-memory address for one child
// against the current hcount/vcount.
module sprite_addr_gen
  import sprite_pkg::*;
(
  input  child_state_t child,
  input  pattern_t     pat,
  input  logic [9:0]   hcount,
  input  logic [9:0]   vcount,
  output logic         hit,
  output logic [19:0]  addr
);

  logic [10:0] x_end;
  logic [10:0] y_end;
  logic [9:0]  dx;
  logic [9:0]  dy;
  logic [19:0] col;

  always_comb begin
    // 11-bit ends keep a sprite hanging past column/row 1023 from wrapping to 0.
    x_end = {1'b0, child.x} + {1'b0, pat.width};
    y_end = {1'b0, child.y} + {1'b0, pat.height};
    dx    = hcount - child.x;
    dy    = vcount - child.y;
    hit   = child.visible
            && (hcount >= child.x) && ({1'b0, hcount} < x_end)
            && (vcount >= child.y) && ({1'b0, vcount} < y_end);
    col   = child.flip ? (20'(pat.width) - 20'd1 - 20'(dx)) : 20'(dx);
    addr  = 20'(pat.base) + 20'(dy) * 20'(pat.width) + col;
  end

endmodule

// File: rtl/sprite_layer.sv
// Double-buffered N-child sprite renderer with a 3-stage pixel pipeline.
// Define SPRITE_LAYER_VSYNC_SWAP_EN to defer buffer swaps to the next frame start.
module sprite_layer
  import sprite_pkg::*;
#(
  parameter logic [5:0] COMPONENT_ID = 6'b001010,
  parameter int N_CHILDREN = 4,
  parameter int N_PATTERNS = 4,
  parameter int PIX_BITS = 2,
  parameter int MEM_DEPTH = 576,
  parameter MEM_INIT_FILE = "",
  parameter logic [N_PATTERNS*PAT_ENTRY_W-1:0] PATTERN_TABLE = '0,
  parameter logic [(2**PIX_BITS)*24-1:0] PALETTE = '0,
  parameter logic [23:0] BG_COLOR = 24'h202020
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [23:0] RGB_output,
  output logic        active_buffer,
  output logic        swap_pending
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [ID_W-1:0]    cmd_id;
  logic [CHILD_W-1:0] cmd_child;
  logic [CTRL_W-1:0]  cmd_ctrl;
  logic [TYPE_W-1:0]  cmd_type;
  logic               cmd_bank;
  logic [DATA_W-1:0]  cmd_data;
  logic               swap_cmd;
  logic               set_cmd;
  logic               pat_ok;
  logic               unused_data_bit;

  assign cmd_id          = writedata[ID_LSB +: ID_W];
  assign cmd_child       = writedata[CHILD_LSB +: CHILD_W];
  assign cmd_ctrl        = writedata[CTRL_LSB +: CTRL_W];
  assign cmd_type        = writedata[TYPE_LSB +: TYPE_W];
  assign cmd_bank        = writedata[BANK_BIT];
  assign cmd_data        = writedata[DATA_W-1:0];
  assign unused_data_bit = cmd_data[10];

  assign swap_cmd = write && (cmd_ctrl == CTRL_SWAP);
  assign set_cmd  = write && (cmd_ctrl == CTRL_SET) && (cmd_id == COMPONENT_ID)
                    && ({1'b0, cmd_child} < 6'(N_CHILDREN));
  assign pat_ok   = {1'b0, cmd_data[4:0]} < 6'(N_PATTERNS);

  logic apply_swap;
  logic swap_bank;
  logic active_q;

`ifdef SPRITE_LAYER_VSYNC_SWAP_EN
  logic pending_q;
  logic pending_bank_q;
  logic frame_start;

  assign frame_start = (hcount == '0) && (vcount == '0);
  assign apply_swap  = pending_q && frame_start;
  assign swap_bank   = pending_bank_q;

  // A swap arriving on the frame-start cycle itself waits for the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q      <= 1'b0;
      pending_bank_q <= 1'b0;
    end else if (swap_cmd) begin
      pending_q      <= 1'b1;
      pending_bank_q <= cmd_bank;
    end else if (apply_swap) begin
      pending_q      <= 1'b0;
    end
  end

  assign swap_pending = pending_q;
`else
  assign apply_swap   = swap_cmd;
  assign swap_bank    = cmd_bank;
  assign swap_pending = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) active_q <= 1'b0;
    else if (apply_swap) active_q <= swap_bank;
  end

  assign active_buffer = active_q;

  child_state_t child_q [2][N_CHILDREN];

  // The back-bank visibility clear comes first so a same-cycle flags write wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N_CHILDREN; i++)
          child_q[b][i] <= '0;
    end else begin
      if (apply_swap)
        for (int i = 0; i < N_CHILDREN; i++)
          child_q[~swap_bank][i].visible <= 1'b0;
      for (int i = 0; i < N_CHILDREN; i++) begin
        if (set_cmd && (cmd_child == 5'(i))) begin
          case (cmd_type)
            TYPE_PATTERN: if (pat_ok) child_q[cmd_bank][i].pattern <= cmd_data[4:0];
            TYPE_X:       child_q[cmd_bank][i].x <= cmd_data[9:0];
            TYPE_Y:       child_q[cmd_bank][i].y <= cmd_data[9:0];
            TYPE_FLAGS: begin
              child_q[cmd_bank][i].visible <= cmd_data[12];
              child_q[cmd_bank][i].flip    <= cmd_data[11];
            end
            default: ;
          endcase
        end
      end
    end
  end

  pattern_t pat_tab [32];

  for (genvar p = 0; p < 32; p++) begin : g_pat
    if (p < N_PATTERNS) begin : g_used
      assign pat_tab[p] = unpack_pattern(PATTERN_TABLE[p*PAT_ENTRY_W +: PAT_ENTRY_W]);
    end else begin : g_empty
      assign pat_tab[p] = '0;
    end
  end

  child_state_t            act_child [N_CHILDREN];
  pattern_t                act_pat   [N_CHILDREN];
  logic [N_CHILDREN-1:0]   hit_v;
  logic [19:0]             addr_v    [N_CHILDREN];

  for (genvar i = 0; i < N_CHILDREN; i++) begin : g_child
    assign act_child[i] = child_q[active_q][i];
    assign act_pat[i]   = pat_tab[act_child[i].pattern];

    sprite_addr_gen u_addr_gen (
      .child  (act_child[i]),
      .pat    (act_pat[i]),
      .hcount (hcount),
      .vcount (vcount),
      .hit    (hit_v[i]),
      .addr   (addr_v[i])
    );
  end

  logic        win_hit;
  logic [19:0] win_addr;

  always_comb begin
    win_hit  = 1'b0;
    win_addr = '0;
    for (int i = N_CHILDREN - 1; i >= 0; i--) begin
      if (hit_v[i]) begin
        win_hit  = 1'b1;
        win_addr = addr_v[i];
      end
    end
  end

  logic [PIX_BITS-1:0] mem [MEM_DEPTH];

  logic                s1_hit;
  logic [19:0]         s1_addr;
  logic                s2_hit;
  logic [PIX_BITS-1:0] s2_pix;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_hit     <= 1'b0;
      s1_addr    <= '0;
      s2_hit     <= 1'b0;
      RGB_output <= BG_COLOR;
    end else begin
      s1_hit     <= win_hit;
      s1_addr    <= win_addr;
      s2_hit     <= s1_hit;
      RGB_output <= (s2_hit && (s2_pix != '0)) ? PALETTE[int'(s2_pix)*24 +: 24] : BG_COLOR;
    end
  end

  // Out-of-range addresses read as index 0, which renders as transparent.
  always_ff @(posedge clk) begin
    s2_pix <= (s1_addr < 20'(MEM_DEPTH)) ? mem[s1_addr[AW-1:0]] : '0;
  end

endmodule
